multicycle_ctrl_unit: RTL
=========================

# multicycle_ctrl_unit

Control unit for the multicycle generation of the RV32I core. It replaces the single-cycle combinational decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles on a shared memory port with a ready handshake. It is parametrised for an extended ALU-op set and for full RV32I conditional branches. It sits between the instruction register/flags and the multicycle datapath muxes, register file and memory port.

## Interface
- EXT_ALU, default 0: 0 selects the 3-bit base ALU op set; 1 selects the 4-bit extended set (adds xor, sll, srl, sra, sltu).
- EXT_BR, default 0: 0 decodes beq only; 1 decodes beq/bne/blt/bge/bltu/bgeu.
- ACW, derived: 3 + EXT_ALU.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces state to FETCH.
- op  in  7  opcode, instr[6:0], taken from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero, lt, ltu  in  1 each  ALU flags (equal, signed less-than, unsigned less-than).
- mem_ready  in  1  memory port completes the current access this cycle.
- pcwrite  out  1  PC register enable.
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register (and oldPC) enable.
- resultsrc  out  2  result mux: 00 = aluout, 01 = data, 10 = ALU direct.
- alusrca  out  2  00 = PC, 01 = oldPC, 10 = rs1.
- alusrcb  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- alucontrol  out  ACW  ALU operation.
- immsrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- regwrite  out  1  register file write enable.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH.
- Outputs are a combinational function of state, plus only the listed mem_ready, flag and field terms. All unlisted outputs are 0 in each state.
- The state register is the only storage. 3-bit op (aluop) is internal.
- FETCH: alusrca=00, alusrcb=10, resultsrc=10, aluop=add. irwrite and pcwrite = mem_ready. Stay while !mem_ready; on mem_ready go to DECODE.
- DECODE: alusrca=01, alusrcb=01, aluop=add (branch target into aluout).
  - lw/sw (0000011/0100011) go to MEMADR.
  - R (0110011) goes to EXECR.
  - I-ALU (0010011) goes to EXECI.
  - jal (1101111) goes to JAL.
  - branch (1100011) goes to BRANCH.
  - Any other opcode: illegal=1 and go to FETCH.
- MEMADR: alusrca=10, alusrcb=01, aluop=add. op[5]=0 goes to MEMREAD; op[5]=1 goes to MEMWRITE.
- MEMREAD: adrsrc=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: resultsrc=01, regwrite=1, then go to FETCH.
- MEMWRITE: adrsrc=1, memwrite=1. Hold until mem_ready, then go to FETCH. memwrite stays high for every wait cycle.
- EXECR / EXECI: alusrca=10, alusrcb=00 (R) or 01 (I), aluop=funct-decoded, then go to ALUWB.
- ALUWB: resultsrc=00, regwrite=1, then go to FETCH.
- JAL: alusrca=01, alusrcb=10, resultsrc=00, pcwrite=1, then go to ALUWB (rd = oldPC+4).
- BRANCH: alusrca=10, alusrcb=00, aluop=sub, resultsrc=00. pcwrite=taken, then go to FETCH.
  - EXT_BR=0: taken = zero for funct3=000, else 0.
  - EXT_BR=1: taken for funct3 000/001/100/101/110/111 = zero / !zero / lt / !lt / ltu / !ltu. Funct3 010/011 give taken=0.
- ALU decode, funct-decoded:
  - funct3 000: sub when op[5]&funct7b5, else add.
  - 010: slt. 110: or. 111: and.
  - Base encodings: add 000, sub 001, and 010, or 011, slt 101.
  - EXT_ALU=1 encodings: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000, sltu 1001. funct3 001 = sll, 011 = sltu, 100 = xor, 101 = sra if funct7b5 else srl.
  - EXT_ALU=0: funct3 001/011/100/101 yield add.
- immsrc is decoded from op in every state: 0100011 gives 01, 1100011 gives 10, 1101111 gives 11, all other opcodes give 00.

## Timing
- Reset, asynchronous: state goes to FETCH on assertion, mid-access included. memwrite and regwrite drop in the same cycle. Outputs then show FETCH values: adrsrc=0, alusrcb=10, resultsrc=10, alucontrol=add, irwrite=pcwrite=mem_ready, all others 0.
- Latency with zero wait states (mem_ready tied high), in cycles:
  - R/I: 4.
  - lw: 5.
  - sw: 4.
  - branch: 3.
  - jal: 4.
- Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle. No other state waits.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- illegal is high only in the DECODE cycle. The next cycle is FETCH at the unchanged PC+4.

## Test plan
- Reset asserted during a 3-cycle MEMWRITE wait: memwrite goes low asynchronously, state is FETCH; after release, irwrite=1 on the first mem_ready.
- add x1,x2,x3 (funct7b5=0), mem_ready=1: FETCH→DECODE→EXECR→ALUWB; alucontrol=add in EXECR, regwrite=1 only in cycle 4.
- lw with mem_ready low for 2 cycles in MEMREAD: 7 cycles total, regwrite=1 only in MEMWB, resultsrc=01.
- EXT_BR=1, bltu with ltu=1, then bgeu with ltu=1: pcwrite=1 in BRANCH for bltu, 0 for bgeu; EXT_BR=0 bne: pcwrite=0.
- EXT_ALU=1, srai (op=0010011, funct3=101, funct7b5=1): alucontrol=1000; EXT_ALU=0, same instruction: alucontrol=000.
- op=0110111 (lui): illegal pulses once in DECODE, next state FETCH, no regwrite or memwrite.

Source files
------------

// File: rtl/multicycle_ctrl_unit.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_unit
//
// Moore control unit for the multicycle RV32I core. A single state register
// sequences fetch, decode, execute, memory access and writeback across several
// cycles. Every output is decoded combinationally from the current state, plus
// mem_ready (FETCH/MEMREAD/MEMWRITE handshake), the ALU flags (BRANCH) and the
// instruction fields (ALU decode, immsrc).
//
// Parameters
//   EXT_ALU  0: 3-bit base ALU op set, 1: 4-bit extended set
//   EXT_BR   0: beq only, 1: beq/bne/blt/bge/bltu/bgeu
//   ACW      derived ALU control width, 3 + EXT_ALU
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset, state -> FETCH
//   op          in   instr[6:0]
//   funct3      in   instr[14:12]
//   funct7b5    in   instr[30]
//   zero/lt/ltu in   ALU flags: equal, signed less-than, unsigned less-than
//   mem_ready   in   memory port completes the current access this cycle
//   pcwrite     out  PC register enable
//   adrsrc      out  memory address select, 0 = PC, 1 = ALU result register
//   memwrite    out  memory write strobe
//   irwrite     out  instruction register / oldPC enable
//   resultsrc   out  00 = aluout, 01 = data, 10 = ALU direct
//   alusrca     out  00 = PC, 01 = oldPC, 10 = rs1
//   alusrcb     out  00 = rs2, 01 = imm, 10 = constant 4
//   alucontrol  out  ALU operation (ACW bits)
//   immsrc      out  00 = I, 01 = S, 10 = B, 11 = J
//   regwrite    out  register file write enable
//   illegal     out  high for the DECODE cycle of an unsupported opcode
//   state_dbg   out  current state for checkers (0 = FETCH, see state_t)
//
// Memory handshake: an access is presented in FETCH, MEMREAD or MEMWRITE and
// completes in the cycle where mem_ready is high; the FSM holds the state (and
// all its strobes) on every cycle where mem_ready is low. mem_ready is ignored
// in every other state.
// -----------------------------------------------------------------------------
module multicycle_ctrl_unit #(
    parameter int  EXT_ALU = 0,
    parameter int  EXT_BR  = 0,
    localparam int ACW     = 3 + EXT_ALU
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [6:0]     op,
    input  logic [2:0]     funct3,
    input  logic           funct7b5,
    input  logic           zero,
    input  logic           lt,
    input  logic           ltu,
    input  logic           mem_ready,
    output logic           pcwrite,
    output logic           adrsrc,
    output logic           memwrite,
    output logic           irwrite,
    output logic [1:0]     resultsrc,
    output logic [1:0]     alusrca,
    output logic [1:0]     alusrcb,
    output logic [ACW-1:0] alucontrol,
    output logic [1:0]     immsrc,
    output logic           regwrite,
    output logic           illegal,
    output logic [3:0]     state_dbg
);

    // Opcodes recognised in DECODE
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Internal ALU request from the FSM to the ALU decoder
    localparam logic [2:0] ALUOP_ADD   = 3'd0;
    localparam logic [2:0] ALUOP_SUB   = 3'd1;
    localparam logic [2:0] ALUOP_FUNCT = 3'd2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    state_t     state;
    logic [2:0] aluop;
    logic       taken;
    logic       taken_base;
    logic       taken_ext;
    logic [2:0] alu_base;
    logic [3:0] alu_ext;
    logic [3:0] alu_sel;
    logic       op_known;

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // State register: the only storage in the block.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) state <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_R:              state <= S_EXECR;
                        OP_I:              state <= S_EXECI;
                        OP_JAL:            state <= S_JAL;
                        OP_BRANCH:         state <= S_BRANCH;
                        default:           state <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    // op[5] separates sw (0100011) from lw (0000011)
                    state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    if (mem_ready) state <= S_MEMWB;
                end
                S_MEMWB: begin
                    state <= S_FETCH;
                end
                S_MEMWRITE: begin
                    if (mem_ready) state <= S_FETCH;
                end
                S_EXECR, S_EXECI: begin
                    state <= S_ALUWB;
                end
                S_ALUWB: begin
                    state <= S_FETCH;
                end
                S_JAL: begin
                    // rd = oldPC + 4 is written back in ALUWB
                    state <= S_ALUWB;
                end
                S_BRANCH: begin
                    state <= S_FETCH;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Opcode legality, used only for the illegal pulse in DECODE.
    // ------------------------------------------------------------------
    always_comb begin
        case (op)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BRANCH: op_known = 1'b1;
            default:                                          op_known = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode. Everything not set in a state stays 0.
    // ------------------------------------------------------------------
    always_comb begin
        pcwrite   = 1'b0;
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        resultsrc = 2'b00;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        regwrite  = 1'b0;
        illegal   = 1'b0;
        aluop     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                // PC+4 goes straight to the PC through the ALU-direct path
                alusrca   = 2'b00;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = mem_ready;
                pcwrite   = mem_ready;
            end
            S_DECODE: begin
                // Precompute oldPC + imm so a branch target sits in aluout
                alusrca = 2'b01;
                alusrcb = 2'b01;
                illegal = ~op_known;
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe is held for every wait cycle until mem_ready
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECR: begin
                alusrca = 2'b10;
                alusrcb = 2'b00;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                resultsrc = 2'b00;
                regwrite  = 1'b1;
            end
            S_JAL: begin
                // Jump target from DECODE is in aluout; ALU forms oldPC + 4
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                resultsrc = 2'b00;
                pcwrite   = 1'b1;
            end
            S_BRANCH: begin
                alusrca   = 2'b10;
                alusrcb   = 2'b00;
                aluop     = ALUOP_SUB;
                resultsrc = 2'b00;
                pcwrite   = taken;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Branch condition. Both decodes are always built; EXT_BR selects.
    // ------------------------------------------------------------------
    always_comb begin
        taken_base = (funct3 == 3'b000) & zero;
        case (funct3)
            3'b000:  taken_ext = zero;
            3'b001:  taken_ext = ~zero;
            3'b100:  taken_ext = lt;
            3'b101:  taken_ext = ~lt;
            3'b110:  taken_ext = ltu;
            3'b111:  taken_ext = ~ltu;
            default: taken_ext = 1'b0;
        endcase
        taken = (EXT_BR != 0) ? taken_ext : taken_base;
    end

    // ------------------------------------------------------------------
    // ALU decoder. Subtraction on funct3=000 needs both op[5] (R-type, so
    // addi with instr[30] set stays an add) and funct7b5.
    // ------------------------------------------------------------------
    always_comb begin
        case (aluop)
            ALUOP_ADD: alu_base = 3'b000;
            ALUOP_SUB: alu_base = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  alu_base = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_base = 3'b101;
                    3'b110:  alu_base = 3'b011;
                    3'b111:  alu_base = 3'b010;
                    default: alu_base = 3'b000; // no base encoding: add
                endcase
            end
        endcase
    end

    always_comb begin
        case (aluop)
            ALUOP_ADD: alu_ext = 4'b0000;
            ALUOP_SUB: alu_ext = 4'b0001;
            default: begin
                case (funct3)
                    3'b000:  alu_ext = (op[5] & funct7b5) ? 4'b0001 : 4'b0000;
                    3'b001:  alu_ext = 4'b0110;
                    3'b010:  alu_ext = 4'b0101;
                    3'b011:  alu_ext = 4'b1001;
                    3'b100:  alu_ext = 4'b0100;
                    3'b101:  alu_ext = funct7b5 ? 4'b1000 : 4'b0111;
                    3'b110:  alu_ext = 4'b0011;
                    default: alu_ext = 4'b0010;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_sel = (EXT_ALU != 0) ? alu_ext : {1'b0, alu_base};
    end

    assign alucontrol = ACW'(alu_sel);

    // ------------------------------------------------------------------
    // Immediate format depends on the opcode only, in every state.
    // ------------------------------------------------------------------
    always_comb begin
        case (op)
            OP_STORE:  immsrc = 2'b01;
            OP_BRANCH: immsrc = 2'b10;
            OP_JAL:    immsrc = 2'b11;
            default:   immsrc = 2'b00;
        endcase
    end

endmodule
